// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: WB has priority, MC results queue in a FIFO with starvation forcing.
// Optional same-cycle MC bypass when the FIFO is empty: define RF_WPORT_BYPASS_EN.
module rf_wport_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_wd,
    output logic        wb_stall,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [4:0]  mc_rd,
    input  logic [31:0] mc_wd,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    output logic [31:0] pend_mask,
    output logic        we3,
    output logic [4:0]  a3,
    output logic [31:0] wd3
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wd;
    } mc_entry_t;

    typedef enum logic [1:0] {SRC_NONE, SRC_WB, SRC_FIFO, SRC_BYP} src_e;

    mc_entry_t        mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic [SW-1:0]    starve_cnt;

    logic             wb_eff, empty, full, force_mc, byp, push, pop, mc_write;
    src_e             src;
    mc_entry_t        head;
    logic [31:0]      pend_next;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        wb_eff   = wb_we && (wb_rd != 5'd0);
        // Reset masks the stored state so only the WB passthrough can write during reset.
        empty    = reset || (count == CW'(0));
        full     = !reset && (count == CW'(DEPTH));
        head     = mem[rd_ptr];
        force_mc = !empty && (starve_cnt == SW'(STARVE_LIMIT));
`ifdef RF_WPORT_BYPASS_EN
        byp      = empty && !reset && !wb_eff && mc_valid;
`else
        byp      = 1'b0;
`endif
        src = SRC_NONE;
        if (force_mc)    src = SRC_FIFO;
        else if (wb_eff) src = SRC_WB;
        else if (!empty) src = SRC_FIFO;
        else if (byp)    src = SRC_BYP;

        mc_ready = !full;
        pop      = (src == SRC_FIFO);
        push     = mc_valid && !full && !byp;
        wb_stall = force_mc && wb_eff;

        we3 = 1'b0;
        a3  = 5'd0;
        wd3 = 32'd0;
        unique case (src)
            SRC_WB: begin
                we3 = 1'b1;
                a3  = wb_rd;
                wd3 = wb_wd;
            end
            SRC_FIFO: begin
                we3 = (head.rd != 5'd0);
                a3  = head.rd;
                wd3 = head.wd;
            end
            SRC_BYP: begin
                we3 = (mc_rd != 5'd0);
                a3  = mc_rd;
                wd3 = mc_wd;
            end
            default: ;
        endcase
        mc_write = we3 && (src == SRC_FIFO || src == SRC_BYP);

        // Clear first so a same-cycle issue to the same register wins.
        pend_next = pend_mask;
        if (mc_write) pend_next[a3] = 1'b0;
        if (iss_valid && iss_rd != 5'd0) pend_next[iss_rd] = 1'b1;
        pend_next[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            pend_mask  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (pop || empty)                        starve_cnt <= '0;
            else if (starve_cnt < SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + SW'(1);
            pend_mask <= pend_next;
        end
    end

    // NOTE: the storage array has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{rd: mc_rd, wd: mc_wd};
    end

    // A re-issue is legal only when the outstanding write to that register retires this cycle.
    a_no_reissue: assert property (@(posedge clk) disable iff (reset)
        (iss_valid && iss_rd != 5'd0) |-> (!pend_mask[iss_rd] || (mc_write && a3 == iss_rd)));

endmodule
